// File: rtl/regfile_scoreboard_if.sv
// Bus between decode/writeback and the scoreboarded register file.
// Read ports, write port, reservation port and pending count travel together;
// clock and reset stay outside as plain module ports.
interface regfile_scoreboard_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2
);
    logic [NUM_READ*ADDRESS_WIDTH-1:0] RA;
    logic [NUM_READ*DATA_WIDTH-1:0]    BusR;
    logic [NUM_READ-1:0]               Busy;
    logic                              RegWr;
    logic [ADDRESS_WIDTH-1:0]          RW;
    logic [DATA_WIDTH-1:0]             BusW;
    logic                              Reserve;
    logic [ADDRESS_WIDTH-1:0]          RD;
    logic [ADDRESS_WIDTH:0]            PendCnt;

    // Pipeline side: issues reads, reservations and writebacks
    modport master (
        output RA, RegWr, RW, BusW, Reserve, RD,
        input  BusR, Busy, PendCnt
    );

    // Register file side
    modport slave (
        input  RA, RegWr, RW, BusW, Reserve, RD,
        output BusR, Busy, PendCnt
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending (scoreboard) bits for the pipelined
// MIPS core. NUM_READ combinational read ports, one clocked write port, one
// clocked reservation port and a registered count of pending registers.
// Register 0 reads as zero, is never written and is never pending.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port onto
// any read port addressing the same register in the same cycle.
module regfile_scoreboard #(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 32,
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    regfile_scoreboard_if.slave  bus
);

    logic [DATA_WIDTH-1:0]         r_regs [DEPTH];
    logic [DEPTH-1:0]              r_pend;
    logic [ADDRESS_WIDTH:0]        r_pend_cnt;

    logic                          w_wr_en;
    logic                          w_rsv_en;
    logic [DEPTH-1:0]              w_set_mask;
    logic [DEPTH-1:0]              w_clr_mask;
    logic [DEPTH-1:0]              w_pend_next;
    logic                          w_cnt_inc;
    logic                          w_cnt_dec;
    logic [NUM_READ*DATA_WIDTH-1:0] w_busr;
    logic [NUM_READ-1:0]           w_busy;

    // Accesses to register 0 are dropped at the source so r0 can never change
    assign w_wr_en  = bus.RegWr   && (bus.RW != '0);
    assign w_rsv_en = bus.Reserve && (bus.RD != '0);

    // One-hot set/clear masks; a reservation overrides a write clear on the same
    // register because the newly issued producer has not written back yet
    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_rsv_en) begin
            w_set_mask[bus.RD] = 1'b1;
        end
        if (w_wr_en) begin
            w_clr_mask[bus.RW] = 1'b1;
        end
        w_clr_mask  = w_clr_mask & ~w_set_mask;
        w_pend_next = (r_pend & ~w_clr_mask) | w_set_mask;
        // Only real 0->1 and 1->0 transitions move the count
        w_cnt_inc   = |(w_set_mask & ~r_pend);
        w_cnt_dec   = |(w_clr_mask &  r_pend);
    end

    // Register storage: async clear, writeback on the rising edge
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_regs[bus.RW] <= bus.BusW;
        end
    end

    // Pending bits and their population count, updated together
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= r_pend_cnt
                          + {{ADDRESS_WIDTH{1'b0}}, w_cnt_inc}
                          - {{ADDRESS_WIDTH{1'b0}}, w_cnt_dec};
        end
    end

    // Combinational read ports; outputs are forced quiet while reset is held so
    // a forwarded write cannot leak through during reset
    always_comb begin
        w_busr = '0;
        w_busy = '0;
        for (int p = 0; p < NUM_READ; p++) begin
            logic [ADDRESS_WIDTH-1:0] w_ra;
            w_ra = bus.RA[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            if (Rst_n && (w_ra != '0)) begin
`ifdef REGFILE_BYPASS_EN
                if (w_wr_en && (bus.RW == w_ra)) begin
                    // Write-through: the value arriving this cycle is the
                    // youngest one, so the consumer need not stall on it
                    w_busr[p*DATA_WIDTH +: DATA_WIDTH] = bus.BusW;
                    w_busy[p]                          = 1'b0;
                end else begin
                    w_busr[p*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra];
                    w_busy[p]                          = r_pend[w_ra];
                end
`else
                w_busr[p*DATA_WIDTH +: DATA_WIDTH] = r_regs[w_ra];
                w_busy[p]                          = r_pend[w_ra];
`endif
            end
        end
    end

    assign bus.BusR    = w_busr;
    assign bus.Busy    = w_busy;
    assign bus.PendCnt = r_pend_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard: directed scenarios plus a
// randomized run compared against an array-based reference model.
module tb_regfile_scoreboard;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic Clk = 1'b0;
    logic Rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [DW-1:0] m_reg  [DEPTH];
    bit            m_pend [DEPTH];

    regfile_scoreboard_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .NUM_READ(NR)) bus ();

    regfile_scoreboard #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW), .NUM_READ(NR)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // Stimulus / model helpers (no checking here)
    task automatic set_idle();
        bus.RA = '0; bus.RegWr = 1'b0; bus.RW = '0; bus.BusW = '0;
        bus.Reserve = 1'b0; bus.RD = '0;
    endtask

    task automatic set_ra(input int a, input int b);
        bus.RA = {AW'(b), AW'(a)};
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_reg[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    // Waits for the rising edge, applies the architectural rules to the model,
    // then steps 1 time unit past the edge
    task automatic tick();
        @(posedge Clk);
        if (Rst_n) begin
            if (bus.RegWr && bus.RW != 0) begin
                m_reg[bus.RW] = bus.BusW;
                m_pend[bus.RW] = 1'b0;
            end
            if (bus.Reserve && bus.RD != 0) m_pend[bus.RD] = 1'b1;
        end
        #1;
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
        return n;
    endfunction

    function automatic logic [DW-1:0] rd(input int p);
        return bus.BusR[p*DW +: DW];
    endfunction

    task automatic test_reset();
        set_idle();
        Rst_n = 1'b0;
        bus.RegWr = 1'b1; bus.RW = 5'd5; bus.BusW = 32'hFFFF_FFFF;
        bus.Reserve = 1'b1; bus.RD = 5'd6;
        set_ra(5, 6);
        tick(); tick();
        model_clear();
        checks++; if (rd(0) !== '0) begin errors++; $display("FAIL reset_busr_held got %h exp %h", rd(0), 32'h0); end
        checks++; if (bus.PendCnt !== '0) begin errors++; $display("FAIL reset_cnt_held got %0d exp 0", bus.PendCnt); end
        @(negedge Clk);
        Rst_n = 1'b1;
        set_idle(); set_ra(5, 6);
        #1;
        checks++; if (rd(0) !== '0 || rd(1) !== '0) begin errors++; $display("FAIL reset_busr got %h/%h exp 0", rd(0), rd(1)); end
        checks++; if (bus.Busy !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", bus.Busy); end
        checks++; if (bus.PendCnt !== '0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", bus.PendCnt); end
        bus.RegWr = 1'b1; bus.RW = 5'd0; bus.BusW = 32'hFFFF_FFFF; set_ra(0, 0);
        #1;
        checks++; if (rd(0) !== '0) begin errors++; $display("FAIL r0_write_same got %h exp 0", rd(0)); end
        tick();
        set_idle(); set_ra(0, 0); #1;
        checks++; if (rd(0) !== '0 || bus.Busy !== 2'b00) begin errors++; $display("FAIL r0_write got %h busy %b exp 0", rd(0), bus.Busy); end
    endtask

    task automatic test_write_read();
        bus.RegWr = 1'b1; bus.RW = 5'd5; bus.BusW = 32'hDEAD_BEEF;
        tick();
        set_idle(); set_ra(5, 5); #1;
        checks++; if (rd(0) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_port0 got %h exp %h", rd(0), 32'hDEAD_BEEF); end
        checks++; if (rd(1) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wr_port1 got %h exp %h", rd(1), 32'hDEAD_BEEF); end
        set_ra(6, 5); #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL rd_r6 got %h exp 0", rd(0)); end
    endtask

    task automatic test_scoreboard();
        bus.Reserve = 1'b1; bus.RD = 5'd3; tick();
        bus.RD = 5'd7; tick();
        set_idle(); set_ra(3, 7); #1;
        checks++; if (bus.PendCnt !== 6'd2) begin errors++; $display("FAIL sb_cnt2 got %0d exp 2", bus.PendCnt); end
        checks++; if (bus.Busy !== 2'b11) begin errors++; $display("FAIL sb_busy got %b exp 11", bus.Busy); end
        bus.RegWr = 1'b1; bus.RW = 5'd3; bus.BusW = 32'h11; tick();
        set_idle(); set_ra(3, 7); #1;
        checks++; if (bus.PendCnt !== 6'd1) begin errors++; $display("FAIL sb_cnt1 got %0d exp 1", bus.PendCnt); end
        checks++; if (bus.Busy !== 2'b10) begin errors++; $display("FAIL sb_busy_clr got %b exp 10", bus.Busy); end
        checks++; if (rd(0) !== 32'h11) begin errors++; $display("FAIL sb_r3 got %h exp 11", rd(0)); end
        bus.Reserve = 1'b1; bus.RD = 5'd7; tick();
        set_idle(); #1;
        checks++; if (bus.PendCnt !== 6'd1) begin errors++; $display("FAIL sb_rereserve got %0d exp 1", bus.PendCnt); end
    endtask

    task automatic test_collision();
        bus.Reserve = 1'b1; bus.RD = 5'd9;
        bus.RegWr = 1'b1; bus.RW = 5'd9; bus.BusW = 32'h22;
        tick();
        set_idle(); set_ra(9, 0); #1;
        checks++; if (rd(0) !== 32'h22) begin errors++; $display("FAIL col_data got %h exp 22", rd(0)); end
        checks++; if (bus.Busy !== 2'b01) begin errors++; $display("FAIL col_busy got %b exp 01", bus.Busy); end
        checks++; if (bus.PendCnt !== 6'd2) begin errors++; $display("FAIL col_cnt got %0d exp 2", bus.PendCnt); end
        bus.Reserve = 1'b1; bus.RD = 5'd0; tick();
        set_idle(); set_ra(0, 0); #1;
        checks++; if (bus.PendCnt !== 6'd2 || bus.Busy !== 2'b00) begin errors++; $display("FAIL col_r0 got %0d busy %b exp 2 00", bus.PendCnt, bus.Busy); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_d;
        logic          exp_b;
        bus.RegWr = 1'b1; bus.RW = 5'd4; bus.BusW = 32'h1234;
        bus.Reserve = 1'b1; bus.RD = 5'd4;
        tick();
        set_idle();
        bus.RegWr = 1'b1; bus.RW = 5'd4; bus.BusW = 32'hA5A5_A5A5; set_ra(4, 4);
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hA5A5_A5A5; exp_b = 1'b0;
`else
        exp_d = 32'h1234; exp_b = 1'b1;
`endif
        checks++; if (rd(0) !== exp_d) begin errors++; $display("FAIL byp_same_data got %h exp %h", rd(0), exp_d); end
        checks++; if (bus.Busy[1] !== exp_b) begin errors++; $display("FAIL byp_same_busy got %b exp %b", bus.Busy[1], exp_b); end
        tick();
        set_idle(); set_ra(4, 4); #1;
        checks++; if (rd(0) !== 32'hA5A5_A5A5 || bus.Busy !== 2'b00) begin errors++; $display("FAIL byp_next got %h busy %b exp a5a5a5a5 00", rd(0), bus.Busy); end
        bus.RegWr = 1'b1; bus.RW = 5'd4; bus.BusW = 32'h5A5A_5A5A;
        bus.Reserve = 1'b1; bus.RD = 5'd4;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h5A5A_5A5A;
`else
        exp_d = 32'hA5A5_A5A5;
`endif
        checks++; if (rd(1) !== exp_d || bus.Busy[1] !== 1'b0) begin errors++; $display("FAIL byp_rsv_same got %h busy %b exp %h 0", rd(1), bus.Busy[1], exp_d); end
        tick();
        set_idle(); set_ra(4, 0); #1;
        checks++; if (rd(0) !== 32'h5A5A_5A5A || bus.Busy[0] !== 1'b1) begin errors++; $display("FAIL byp_rsv_next got %h busy %b exp 5a5a5a5a 1", rd(0), bus.Busy[0]); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            int            ra [NR];
            logic [DW-1:0] exp_d;
            logic          exp_b;
            bus.RegWr   = 1'($urandom);
            bus.RW      = AW'($urandom_range(0, 7));
            bus.BusW    = $urandom;
            bus.Reserve = 1'($urandom);
            bus.RD      = AW'($urandom_range(0, 7));
            ra[0] = $urandom_range(0, 7);
            ra[1] = $urandom_range(0, 31);
            set_ra(ra[0], ra[1]);
            #1;
            for (int p = 0; p < NR; p++) begin
                if (ra[p] == 0) begin
                    exp_d = '0; exp_b = 1'b0;
`ifdef REGFILE_BYPASS_EN
                end else if (bus.RegWr && int'(bus.RW) == ra[p]) begin
                    exp_d = bus.BusW; exp_b = 1'b0;
`endif
                end else begin
                    exp_d = m_reg[ra[p]]; exp_b = m_pend[ra[p]];
                end
                checks++; if (rd(p) !== exp_d) begin errors++; $display("FAIL rand_busr%0d cyc %0d got %h exp %h", p, c, rd(p), exp_d); end
                checks++; if (bus.Busy[p] !== exp_b) begin errors++; $display("FAIL rand_busy%0d cyc %0d got %b exp %b", p, c, bus.Busy[p], exp_b); end
            end
            checks++; if (int'(bus.PendCnt) !== model_cnt()) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", c, bus.PendCnt, model_cnt()); end
            tick();
        end
        set_idle();
    endtask

    task automatic test_async_reset();
        @(negedge Clk); Rst_n = 1'b0; #1; Rst_n = 1'b1; model_clear();
        for (int r = 10; r < 15; r++) begin
            bus.Reserve = 1'b1; bus.RD = AW'(r);
            bus.RegWr = 1'b1; bus.RW = AW'(r - 8); bus.BusW = 32'hC000_0000 + 32'(r);
            tick();
        end
        set_idle(); set_ra(5, 12); #1;
        checks++; if (bus.PendCnt !== 6'd5) begin errors++; $display("FAIL ar_cnt5 got %0d exp 5", bus.PendCnt); end
        checks++; if (rd(0) !== 32'hC000_000D || bus.Busy !== 2'b10) begin errors++; $display("FAIL ar_pre got %h busy %b exp c000000d 10", rd(0), bus.Busy); end
        #2;
        Rst_n = 1'b0;
        #1;
        checks++; if (bus.PendCnt !== '0) begin errors++; $display("FAIL ar_cnt got %0d exp 0", bus.PendCnt); end
        checks++; if (rd(0) !== '0 || bus.Busy !== 2'b00) begin errors++; $display("FAIL ar_out got %h busy %b exp 0 00", rd(0), bus.Busy); end
        bus.RegWr = 1'b1; bus.RW = 5'd5; bus.BusW = 32'hBAD0_BAD0;
        bus.Reserve = 1'b1; bus.RD = 5'd6;
        tick();
        model_clear();
        @(negedge Clk); Rst_n = 1'b1; set_idle(); set_ra(5, 6); #1;
        checks++; if (rd(0) !== '0 || bus.Busy !== 2'b00 || bus.PendCnt !== '0) begin errors++; $display("FAIL ar_drop got %h busy %b cnt %0d exp 0", rd(0), bus.Busy, bus.PendCnt); end
    endtask

    initial begin
        set_idle();
        model_clear();
        #2;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_collision();
        test_bypass();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
